// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully-connected layer sequencer.
//   fc_seq_state_t : sequencer FSM state encoding
//   FC_N_IN / FC_N_OUT / FC_RD_LAT : default layer geometry and read latency
//   idx_width()    : index width helper, never narrower than one bit
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT,
        DONE
    } fc_seq_state_t;

    localparam int unsigned FC_N_IN   = 110;
    localparam int unsigned FC_N_OUT  = 16;
    localparam int unsigned FC_RD_LAT = 2;

    // A single-entry range still needs one bit to carry index 0.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fc_lat_pipe.sv
// DEPTH-stage, WIDTH-bit shift register that aligns read-side control
// strobes with the memory read latency. Shifts every cycle.
//   clk, rst_n : clock, asynchronous active-low clear of every stage
//   i_d        : strobes entering the pipe
//   o_q        : strobes from DEPTH cycles earlier (i_d itself when DEPTH=0)
module fc_lat_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = clk ^ rst_n;
            assign o_q      = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            // NOTE: the stages hold control strobes, not data, so they are
            // cleared on reset; a stale strobe would fire a spurious MAC.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/fc_seq_ctrl.sv
// Loop sequencer for one fully-connected layer. For each output neuron it
// sweeps all input indices, issuing a read/advance strobe, then waits out the
// read latency and offers the accumulated result on a valid/ready handshake.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   i_start                    : begin a layer (sampled only while idle)
//   i_stall                    : freeze the input sweep
//   o_busy, o_done             : layer in progress / one-cycle completion pulse
//   o_rd_en, o_in_idx          : read strobe and input index being read
//   o_out_idx                  : output neuron currently being computed
//   o_mac_en, o_acc_clr, o_acc_last : read strobe / first / last flags,
//                                delayed by RD_LAT to meet the MAC input data
//   o_out_valid, i_out_ready   : result handshake for o_out_idx
module fc_seq_ctrl
    import fc_pkg::*;
#(
    parameter int unsigned N_IN   = FC_N_IN,
    parameter int unsigned N_OUT  = FC_N_OUT,
    parameter int unsigned RD_LAT = FC_RD_LAT,
    parameter int unsigned IDX_W  = idx_width(N_IN),
    parameter int unsigned OIDX_W = idx_width(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [IDX_W-1:0]  o_in_idx,
    output logic [OIDX_W-1:0] o_out_idx,
    output logic              o_mac_en,
    output logic              o_acc_clr,
    output logic              o_acc_last,
    output logic              o_out_valid,
    input  logic              i_out_ready
);

    localparam logic [IDX_W-1:0]  IN_LAST    = IDX_W'(N_IN - 1);
    localparam logic [OIDX_W-1:0] OUT_LAST   = OIDX_W'(N_OUT - 1);
    // Drain counter counts down to zero, so it loads RD_LAT-1.
    localparam logic [2:0]        DRAIN_INIT = 3'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    fc_seq_state_t     r_state;
    fc_seq_state_t     w_next;
    logic [IDX_W-1:0]  r_in_idx;
    logic [OIDX_W-1:0] r_out_idx;
    logic [2:0]        r_drain_cnt;
    logic              w_rd_en;
    logic              w_in_last;
    logic              w_out_last;
    logic [2:0]        w_pipe_q;

    assign w_in_last  = (r_in_idx == IN_LAST);
    assign w_out_last = (r_out_idx == OUT_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // NOTE: w_next defaults to the current state before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = RUN;
            RUN:     if (w_rd_en && w_in_last) w_next = (RD_LAT == 0) ? OUT : DRAIN;
            DRAIN:   if (r_drain_cnt == '0) w_next = OUT;
            OUT:     if (i_out_ready) w_next = w_out_last ? DONE : RUN;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_rd_en     = (r_state == RUN) && !i_stall;
        o_busy      = (r_state != IDLE);
        o_done      = (r_state == DONE);
        o_out_valid = (r_state == OUT);
    end

    // Index and drain bookkeeping. The drain counter is reloaded throughout
    // RUN so it is armed on the cycle DRAIN is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_idx    <= '0;
            r_out_idx   <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (r_state == IDLE && i_start) begin
                r_in_idx  <= '0;
                r_out_idx <= '0;
            end
            if (w_rd_en) r_in_idx <= w_in_last ? '0 : r_in_idx + IDX_W'(1);
            if (r_state == RUN)
                r_drain_cnt <= DRAIN_INIT;
            else if (r_state == DRAIN && r_drain_cnt != '0)
                r_drain_cnt <= r_drain_cnt - 3'd1;
            if (r_state == OUT && i_out_ready)
                r_out_idx <= w_out_last ? '0 : r_out_idx + OIDX_W'(1);
        end
    end

    fc_lat_pipe #(
        .DEPTH(RD_LAT),
        .WIDTH(3)
    ) u_lat_pipe (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  ({w_rd_en, w_rd_en && (r_in_idx == '0), w_rd_en && w_in_last}),
        .o_q  (w_pipe_q)
    );

    assign o_rd_en    = w_rd_en;
    assign o_in_idx   = r_in_idx;
    assign o_out_idx  = r_out_idx;
    assign o_mac_en   = w_pipe_q[2];
    assign o_acc_clr  = w_pipe_q[1];
    assign o_acc_last = w_pipe_q[0];

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Directed bench for fc_seq_ctrl: a 4x3 layer with RD_LAT=2 (stall,
// back-pressure, ignored start, mid-layer reset) and a 2x1 layer with
// RD_LAT=0. Expected values are hand-derived cycle offsets from the first
// RUN cycle.
module tb_fc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stall, out_ready;
    logic       busy, done, rd_en, mac_en, acc_clr, acc_last, out_valid;
    logic [1:0] in_idx, out_idx;

    logic       start0;
    logic       busy0, done0, rd_en0, mac_en0, acc_clr0, acc_last0, out_valid0;
    logic [0:0] in_idx0, out_idx0;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-offset stimulus and recorded observations for the 4x3 instance.
    logic s_start [64];
    logic s_stall [64];
    logic s_ready [64];
    logic r_rd [64], r_mac [64], r_clr [64], r_last [64];
    logic r_ov [64], r_done [64], r_busy [64];
    int   r_in [64], r_out [64];
    int   c_rd, c_mac, c_clr, c_last, c_ov, c_done;

    always #5 clk = ~clk;

    fc_seq_ctrl #(.N_IN(4), .N_OUT(3), .RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_stall(stall),
        .o_busy(busy), .o_done(done), .o_rd_en(rd_en), .o_in_idx(in_idx),
        .o_out_idx(out_idx), .o_mac_en(mac_en), .o_acc_clr(acc_clr),
        .o_acc_last(acc_last), .o_out_valid(out_valid), .i_out_ready(out_ready)
    );

    fc_seq_ctrl #(.N_IN(2), .N_OUT(1), .RD_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_start(start0), .i_stall(1'b0),
        .o_busy(busy0), .o_done(done0), .o_rd_en(rd_en0), .o_in_idx(in_idx0),
        .o_out_idx(out_idx0), .o_mac_en(mac_en0), .o_acc_clr(acc_clr0),
        .o_acc_last(acc_last0), .o_out_valid(out_valid0), .i_out_ready(1'b1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 64; i++) begin
            s_start[i] = 1'b0;
            s_stall[i] = 1'b0;
            s_ready[i] = 1'b1;
        end
    endtask

    // Entered just after a rising edge with the DUT idle. Pulses start, then
    // records ncyc cycles; offset 0 is the first RUN cycle. Returns just
    // after the rising edge that ends the last recorded cycle.
    task automatic run_layer(input int ncyc);
        c_rd = 0; c_mac = 0; c_clr = 0; c_last = 0; c_ov = 0; c_done = 0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int off = 0; off < ncyc; off++) begin
            start     = s_start[off];
            stall     = s_stall[off];
            out_ready = s_ready[off];
            @(negedge clk);
            r_rd[off] = rd_en;  r_mac[off] = mac_en; r_clr[off] = acc_clr;
            r_last[off] = acc_last; r_ov[off] = out_valid; r_done[off] = done;
            r_busy[off] = busy; r_in[off] = int'(in_idx); r_out[off] = int'(out_idx);
            c_rd += int'(rd_en);  c_mac += int'(mac_en); c_clr += int'(acc_clr);
            c_last += int'(acc_last); c_ov += int'(out_valid); c_done += int'(done);
            @(posedge clk); #1;
        end
        start = 1'b0; stall = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; out_ready = 1'b1; start0 = 1'b0;
        #12;
        // Reset state.
        check("rst_busy", busy, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_idx", in_idx, 0);
        check("rst_out_idx", out_idx, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // RD_LAT=0, 2x1 layer: start cycle is cycle 0, done on cycle 4.
        start0 = 1'b1;
        @(negedge clk);
        check("l0_c0_busy", busy0, 0);
        @(posedge clk); #1; start0 = 1'b0;
        @(negedge clk);
        check("l0_c1_rd", rd_en0, 1);
        check("l0_c1_mac", mac_en0, 1);
        check("l0_c1_clr", acc_clr0, 1);
        check("l0_c1_last", acc_last0, 0);
        @(negedge clk);
        check("l0_c2_in_idx", in_idx0, 1);
        check("l0_c2_last", acc_last0, 1);
        check("l0_c2_mac", mac_en0, 1);
        @(negedge clk);
        check("l0_c3_valid", out_valid0, 1);
        check("l0_c3_rd", rd_en0, 0);
        @(negedge clk);
        check("l0_c4_done", done0, 1);
        @(negedge clk);
        check("l0_c5_done", done0, 0);
        check("l0_c5_busy", busy0, 0);
        @(posedge clk); #1;

        // Free-running 4x3 layer: 7 cycles per output, DONE at offset 21.
        clear_stim();
        run_layer(25);
        check("t1_rd_count", c_rd, 12);
        check("t1_mac_count", c_mac, 12);
        for (int i = 0; i < 4; i++) check($sformatf("t1_in_idx_%0d", i), r_in[i], i);
        check("t1_rd_off4", r_rd[4], 0);
        check("t1_mac_off2", r_mac[2], 1);
        check("t1_mac_off6", r_mac[6], 0);
        check("t1_clr_off2", r_clr[2], 1);
        check("t1_last_off5", r_last[5], 1);
        check("t1_valid_off5", r_ov[5], 0);
        check("t1_valid_off6", r_ov[6], 1);
        check("t1_valid_off13", r_ov[13], 1);
        check("t1_valid_off20", r_ov[20], 1);
        check("t1_valid_count", c_ov, 3);
        check("t1_out_idx_off7", r_out[7], 1);
        check("t1_out_idx_off14", r_out[14], 2);
        check("t1_done_off21", r_done[21], 1);
        check("t1_done_count", c_done, 1);
        check("t1_busy_off21", r_busy[21], 1);
        check("t1_busy_off22", r_busy[22], 0);

        // Stall offsets 2..4 while in_idx=2; output 0 stretches to 10 cycles.
        clear_stim();
        for (int i = 2; i <= 4; i++) s_stall[i] = 1'b1;
        run_layer(27);
        for (int i = 2; i <= 4; i++) begin
            check($sformatf("t2_in_idx_hold_%0d", i), r_in[i], 2);
            check($sformatf("t2_rd_low_%0d", i), r_rd[i], 0);
            check($sformatf("t2_mac_gap_%0d", i + 2), r_mac[i+2], 0);
        end
        check("t2_rd_off5", r_rd[5], 1);
        check("t2_mac_off7", r_mac[7], 1);
        n = 0;
        for (int i = 0; i < 10; i++) n += int'(r_mac[i]);
        check("t2_mac_out0", n, 4);
        check("t2_mac_count", c_mac, 12);
        check("t2_clr_off2", r_clr[2], 1);
        check("t2_clr_off12", r_clr[12], 1);
        check("t2_clr_off19", r_clr[19], 1);
        check("t2_clr_count", c_clr, 3);
        check("t2_last_off8", r_last[8], 1);
        check("t2_last_count", c_last, 3);
        check("t2_done_off24", r_done[24], 1);

        // Back-pressure: out_ready low for offsets 6..10 of output 0.
        clear_stim();
        for (int i = 6; i <= 10; i++) s_ready[i] = 1'b0;
        run_layer(30);
        for (int i = 6; i <= 10; i++) begin
            check($sformatf("t3_valid_held_%0d", i), r_ov[i], 1);
            check($sformatf("t3_out_idx_%0d", i), r_out[i], 0);
            check($sformatf("t3_rd_low_%0d", i), r_rd[i], 0);
        end
        check("t3_valid_off11", r_ov[11], 1);
        check("t3_valid_off12", r_ov[12], 0);
        check("t3_out_idx_off12", r_out[12], 1);
        check("t3_rd_off12", r_rd[12], 1);
        check("t3_done_off26", r_done[26], 1);
        check("t3_done_count", c_done, 1);

        // start held in RUN, OUT and DONE is ignored.
        clear_stim();
        s_start[1] = 1'b1; s_start[2] = 1'b1; s_start[3] = 1'b1;
        s_start[6] = 1'b1; s_start[21] = 1'b1;
        run_layer(30);
        check("t4_in_idx_off1", r_in[1], 1);
        check("t4_in_idx_off3", r_in[3], 3);
        check("t4_out_idx_off7", r_out[7], 1);
        check("t4_out_idx_off14", r_out[14], 2);
        check("t4_rd_count", c_rd, 12);
        check("t4_done_count", c_done, 1);
        n = 0;
        for (int i = 22; i < 30; i++) n += int'(r_busy[i]);
        check("t4_busy_after_done", n, 0);

        // Asynchronous reset mid-RUN at out_idx=1, in_idx=2.
        clear_stim();
        run_layer(9);
        check("t5_pre_in_idx", in_idx, 2);
        check("t5_pre_out_idx", out_idx, 1);
        check("t5_pre_mac", mac_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rd_en", rd_en, 0);
        check("t5_rst_mac_en", mac_en, 0);
        check("t5_rst_in_idx", in_idx, 0);
        check("t5_rst_out_idx", out_idx, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_layer(23);
        check("t5_rd_count", c_rd, 12);
        check("t5_mac_count", c_mac, 12);
        check("t5_done_off21", r_done[21], 1);
        check("t5_done_count", c_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
